// File: rtl/obi_pkg.sv
// Shared constants and types for the 3-to-1 OBI mux and its arbiter.
package obi_pkg;

  localparam logic [31:0] OBI_DEADBEEF = 32'hDEAD_BEEF;

  localparam int OBI_IDX_W = 2;
  typedef logic [OBI_IDX_W-1:0] obi_idx_t;

  localparam obi_idx_t OBI_IDX_0 = 2'd0;
  localparam obi_idx_t OBI_IDX_1 = 2'd1;
  localparam obi_idx_t OBI_IDX_2 = 2'd2;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } obi_state_e;

  // Next controller index, wrapping 2 -> 0.
  function automatic obi_idx_t obi_next_idx(input obi_idx_t i);
    return (i == OBI_IDX_2) ? OBI_IDX_0 : obi_idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/obi_rr_arbiter_3.sv
// 3-way round-robin arbiter with address-phase lock.
// Define OBI_MUX_FIXED_PRIO_EN for fixed priority 0 > 1 > 2.
module obi_rr_arbiter_3
  import obi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       en_i,
  input  logic       advance_i,
  output logic [2:0] gnt_o,
  output obi_idx_t   idx_o,
  output logic       valid_o
);

  obi_idx_t w_start;
  obi_idx_t w_c1;
  obi_idx_t w_c2;
  obi_idx_t w_scan_idx;
  obi_idx_t w_sel_idx;
  logic     r_lock;
  obi_idx_t r_lock_idx;

`ifdef OBI_MUX_FIXED_PRIO_EN
  assign w_start = OBI_IDX_0;
`else
  obi_idx_t r_rr_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_last <= OBI_IDX_2;
    end else if (advance_i) begin
      r_rr_last <= w_sel_idx;
    end
  end

  assign w_start = obi_next_idx(r_rr_last);
`endif

  assign w_c1 = obi_next_idx(w_start);
  assign w_c2 = obi_next_idx(w_c1);

  // Later assignments take precedence, so w_start wins over w_c1 over w_c2.
  always_comb begin
    w_scan_idx = w_c2;
    if (req_i[w_c1]) w_scan_idx = w_c1;
    if (req_i[w_start]) w_scan_idx = w_start;
  end

  assign w_sel_idx = r_lock ? r_lock_idx : w_scan_idx;
  assign idx_o     = w_sel_idx;
  assign valid_o   = en_i && req_i[w_sel_idx];

  for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
    assign gnt_o[gi] = valid_o && (w_sel_idx == obi_idx_t'(gi));
  end

  // A presented-but-ungranted request freezes the selection until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock     <= 1'b0;
      r_lock_idx <= OBI_IDX_0;
    end else if (advance_i) begin
      r_lock <= 1'b0;
    end else if (valid_o) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel_idx;
    end else begin
      r_lock <= 1'b0;
    end
  end

endmodule

// File: rtl/obi_mux_3_to_1.sv
// Three OBI controllers onto one peripheral port, single outstanding read.
// Define OBI_MUX_FIXED_PRIO_EN for fixed priority instead of round-robin.
module obi_mux_3_to_1
  import obi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ctrl0_req_i,
  output logic        ctrl0_gnt_o,
  input  logic [31:0] ctrl0_addr_i,
  input  logic        ctrl0_we_i,
  input  logic [3:0]  ctrl0_be_i,
  input  logic [31:0] ctrl0_wdata_i,
  output logic        ctrl0_rvalid_o,
  output logic [31:0] ctrl0_rdata_o,
  input  logic        ctrl1_req_i,
  output logic        ctrl1_gnt_o,
  input  logic [31:0] ctrl1_addr_i,
  input  logic        ctrl1_we_i,
  input  logic [3:0]  ctrl1_be_i,
  input  logic [31:0] ctrl1_wdata_i,
  output logic        ctrl1_rvalid_o,
  output logic [31:0] ctrl1_rdata_o,
  input  logic        ctrl2_req_i,
  output logic        ctrl2_gnt_o,
  input  logic [31:0] ctrl2_addr_i,
  input  logic        ctrl2_we_i,
  input  logic [3:0]  ctrl2_be_i,
  input  logic [31:0] ctrl2_wdata_i,
  output logic        ctrl2_rvalid_o,
  output logic [31:0] ctrl2_rdata_o,
  output logic        port_req_o,
  input  logic        port_gnt_i,
  output logic [31:0] port_addr_o,
  output logic        port_we_o,
  output logic [3:0]  port_be_o,
  output logic [31:0] port_wdata_o,
  input  logic        port_rvalid_i,
  input  logic [31:0] port_rdata_i,
  output logic        timeout_o
);

  localparam bit          TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [2:0]       w_req;
  logic [2:0]       w_arb_gnt;
  obi_idx_t         w_arb_idx;
  logic             w_arb_valid;
  logic             w_accept;
  logic             w_rsp_active;
  logic             w_timeout;
  logic             w_sel_we;
  logic [2:0]       w_ctrl_gnt;
  logic [2:0]       w_ctrl_rvalid;
  logic [31:0]      w_ctrl_rdata [3];
  obi_state_e       r_state;
  obi_state_e       w_state_next;
  obi_idx_t         r_owner;
  obi_idx_t         w_owner_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_req = {ctrl2_req_i, ctrl1_req_i, ctrl0_req_i};

  obi_rr_arbiter_3 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (w_req),
    .en_i      (r_state == IDLE),
    .advance_i (w_accept),
    .gnt_o     (w_arb_gnt),
    .idx_o     (w_arb_idx),
    .valid_o   (w_arb_valid)
  );

  always_comb begin
    port_addr_o  = ctrl0_addr_i;
    w_sel_we     = ctrl0_we_i;
    port_be_o    = ctrl0_be_i;
    port_wdata_o = ctrl0_wdata_i;
    case (w_arb_idx)
      OBI_IDX_1: begin
        port_addr_o  = ctrl1_addr_i;
        w_sel_we     = ctrl1_we_i;
        port_be_o    = ctrl1_be_i;
        port_wdata_o = ctrl1_wdata_i;
      end
      OBI_IDX_2: begin
        port_addr_o  = ctrl2_addr_i;
        w_sel_we     = ctrl2_we_i;
        port_be_o    = ctrl2_be_i;
        port_wdata_o = ctrl2_wdata_i;
      end
      default: ;
    endcase
  end

  // Handshake outputs are forced low while reset is held, not just after an edge.
  assign port_we_o    = w_sel_we;
  assign port_req_o   = rst_ni && w_arb_valid;
  assign w_accept     = port_req_o && port_gnt_i;
  assign w_rsp_active = rst_ni && (r_state == WAIT_RESP);
  assign w_timeout    = TO_EN && w_rsp_active && !port_rvalid_i && (r_cnt == CNT_LAST);
  assign timeout_o    = w_timeout;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ctrl
    logic w_is_owner;
    assign w_is_owner        = (r_owner == obi_idx_t'(gi));
    assign w_ctrl_gnt[gi]    = rst_ni && w_arb_gnt[gi] && port_gnt_i;
    assign w_ctrl_rvalid[gi] = w_rsp_active && w_is_owner && (port_rvalid_i || w_timeout);
    assign w_ctrl_rdata[gi]  = (w_timeout && w_is_owner) ? OBI_DEADBEEF : port_rdata_i;
  end

  assign ctrl0_gnt_o    = w_ctrl_gnt[0];
  assign ctrl1_gnt_o    = w_ctrl_gnt[1];
  assign ctrl2_gnt_o    = w_ctrl_gnt[2];
  assign ctrl0_rvalid_o = w_ctrl_rvalid[0];
  assign ctrl1_rvalid_o = w_ctrl_rvalid[1];
  assign ctrl2_rvalid_o = w_ctrl_rvalid[2];
  assign ctrl0_rdata_o  = w_ctrl_rdata[0];
  assign ctrl1_rdata_o  = w_ctrl_rdata[1];
  assign ctrl2_rdata_o  = w_ctrl_rdata[2];

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_sel_we) begin
          w_state_next = WAIT_RESP;
          w_owner_next = w_arb_idx;
          w_cnt_next   = '0;
        end
      end
      WAIT_RESP: begin
        // Return happens one cycle after rvalid; no grant is issued in the rvalid cycle.
        if (port_rvalid_i || w_timeout) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (TO_EN) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= OBI_IDX_0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_obi_mux_3_to_1.sv
// Self-checking bench for obi_mux_3_to_1 (TIMEOUT_CYCLES=4); honours OBI_MUX_FIXED_PRIO_EN.
module tb_obi_mux_3_to_1;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        port_gnt;
  logic        port_rvalid;
  logic [31:0] port_rdata;

  wire  [2:0]  gnt;
  wire  [2:0]  rvalid;
  wire  [31:0] rdata [3];
  wire         port_req;
  wire         port_we;
  wire  [31:0] port_addr;
  wire  [31:0] port_wdata;
  wire  [3:0]  port_be;
  wire         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_wait  = 0;
  int m_last  = 2;
  int m_hold  = -1;

  always #5 clk = ~clk;

  obi_mux_3_to_1 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ctrl0_req_i    (req[0]),
    .ctrl0_gnt_o    (gnt[0]),
    .ctrl0_addr_i   (addr[0]),
    .ctrl0_we_i     (we[0]),
    .ctrl0_be_i     (be[0]),
    .ctrl0_wdata_i  (wdata[0]),
    .ctrl0_rvalid_o (rvalid[0]),
    .ctrl0_rdata_o  (rdata[0]),
    .ctrl1_req_i    (req[1]),
    .ctrl1_gnt_o    (gnt[1]),
    .ctrl1_addr_i   (addr[1]),
    .ctrl1_we_i     (we[1]),
    .ctrl1_be_i     (be[1]),
    .ctrl1_wdata_i  (wdata[1]),
    .ctrl1_rvalid_o (rvalid[1]),
    .ctrl1_rdata_o  (rdata[1]),
    .ctrl2_req_i    (req[2]),
    .ctrl2_gnt_o    (gnt[2]),
    .ctrl2_addr_i   (addr[2]),
    .ctrl2_we_i     (we[2]),
    .ctrl2_be_i     (be[2]),
    .ctrl2_wdata_i  (wdata[2]),
    .ctrl2_rvalid_o (rvalid[2]),
    .ctrl2_rdata_o  (rdata[2]),
    .port_req_o     (port_req),
    .port_gnt_i     (port_gnt),
    .port_addr_o    (port_addr),
    .port_we_o      (port_we),
    .port_be_o      (port_be),
    .port_wdata_o   (port_wdata),
    .port_rvalid_i  (port_rvalid),
    .port_rdata_i   (port_rdata),
    .timeout_o      (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who owns the address phase: a held (ungranted) controller, else first requester in rotation.
  function automatic int model_winner();
    int start;
    if (m_hold >= 0) return m_hold;
`ifdef OBI_MUX_FIXED_PRIO_EN
    start = 0;
`else
    start = (m_last + 1) % 3;
`endif
    for (int k = 0; k < 3; k++) begin
      if (req[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_port_req", {31'd0, port_req}, 32'd0);
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
      end else if (!m_busy) begin
        int w;
        logic [2:0] eg;
        bit ep;
        w  = model_winner();
        ep = (w >= 0) && req[w];
        eg = 3'b000;
        if (ep && port_gnt) eg[w] = 1'b1;
        chk("m_port_req", {31'd0, port_req}, {31'd0, ep});
        chk("m_gnt", {29'd0, gnt}, {29'd0, eg});
        chk("m_rvalid_idle", {29'd0, rvalid}, 32'd0);
        chk("m_timeout_idle", {31'd0, timeout}, 32'd0);
        if (ep) begin
          chk("m_port_addr", port_addr, addr[w]);
          chk("m_port_we", {31'd0, port_we}, {31'd0, we[w]});
          chk("m_port_be", {28'd0, port_be}, {28'd0, be[w]});
          chk("m_port_wdata", port_wdata, wdata[w]);
        end
        for (int k = 0; k < 3; k++) chk("m_rdata_idle", rdata[k], port_rdata);
      end else begin
        bit to;
        logic [2:0] ev;
        to = (m_wait == TO - 1) && !port_rvalid;
        ev = 3'b000;
        ev[m_owner] = port_rvalid || to;
        chk("m_port_req_wait", {31'd0, port_req}, 32'd0);
        chk("m_gnt_wait", {29'd0, gnt}, 32'd0);
        chk("m_rvalid_wait", {29'd0, rvalid}, {29'd0, ev});
        chk("m_timeout_wait", {31'd0, timeout}, {31'd0, to});
        for (int k = 0; k < 3; k++) begin
          chk("m_rdata_wait", rdata[k], (to && k == m_owner) ? 32'hDEAD_BEEF : port_rdata);
        end
      end
    end
  end

  // Model state advances on the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_owner = 0; m_wait = 0; m_last = 2; m_hold = -1;
      end else if (!m_busy) begin
        int w;
        w = model_winner();
        if (w >= 0 && req[w] && port_gnt) begin
`ifndef OBI_MUX_FIXED_PRIO_EN
          m_last = w;
`endif
          m_hold = -1;
          if (!we[w]) begin
            m_busy = 1'b1; m_owner = w; m_wait = 0;
          end
        end else if (w >= 0 && req[w]) begin
          m_hold = w;
        end else begin
          m_hold = -1;
        end
      end else begin
        if (port_rvalid || (m_wait == TO - 1)) m_busy = 1'b0;
        else m_wait++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b000; we = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0; wdata[k] = 32'h0; be[k] = 4'h0;
    end
    port_gnt = 1'b0; port_rvalid = 1'b0; port_rdata = 32'h0;

    // Reset: requests and grants present, outputs held low
    #1;
    req[0] = 1'b1; port_gnt = 1'b1;
    sample();
    chk("reset_port_req", {31'd0, port_req}, 32'd0);
    chk("reset_gnt0", {31'd0, gnt[0]}, 32'd0);
    req[0] = 1'b0; port_gnt = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // Simultaneous writes rotate 0,1,2,0
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h1000 + 32'(k * 4); wdata[k] = 32'hA000 + 32'(k); be[k] = 4'hF;
    end
    req = 3'b111; we = 3'b111; port_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] eg;
      eg = 3'b001 << (i % 3);
      sample();
      chk("wr_rr_gnt", {29'd0, gnt}, {29'd0, eg});
      chk("wr_rr_addr", port_addr, 32'h1000 + 32'((i % 3) * 4));
      chk("wr_rr_no_rvalid", {29'd0, rvalid}, 32'd0);
      $display("[TB] write burst cycle %0d: gnt=%b addr=%h", i, gnt, port_addr);
      step();
    end
    req = 3'b000; port_gnt = 1'b0;
    step();

    // ctrl1 read with delayed grant; address locked while ctrl2 joins
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h100;
    sample();
    chk("lock_addr_c0", port_addr, 32'h100);
    chk("lock_gnt1_c0", {31'd0, gnt[1]}, 32'd0);
    step();
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h200;
    for (int i = 1; i < 3; i++) begin
      sample();
      chk("lock_addr_hold", port_addr, 32'h100);
      chk("lock_gnt_none", {29'd0, gnt}, 32'd0);
      step();
    end
    port_gnt = 1'b1;
    sample();
    chk("lock_gnt1_c3", {29'd0, gnt}, 32'b010);
    $display("[TB] ctrl1 read 0x100 granted: gnt=%b", gnt);
    step();
    req[1] = 1'b0; port_gnt = 1'b0;
    sample();
    chk("rd1_wait_no_rvalid", {29'd0, rvalid}, 32'd0);
    step();
    port_rvalid = 1'b1; port_rdata = 32'h1234_5678;
    sample();
    chk("rd1_rvalid", {29'd0, rvalid}, 32'b010);
    chk("rd1_rdata", rdata[1], 32'h1234_5678);
    chk("rd1_gnt2_blocked", {31'd0, gnt[2]}, 32'd0);
    $display("[TB] ctrl1 read response: rvalid=%b rdata=%h", rvalid, rdata[1]);
    step();
    port_rvalid = 1'b0; port_gnt = 1'b1;
    sample();
    chk("wr2_after_rd1", {29'd0, gnt}, 32'b100);
    chk("wr2_addr", port_addr, 32'h200);
    step();
    req[2] = 1'b0; port_gnt = 1'b0;
    step();

    // ctrl0 read blocks ctrl2 until the cycle after rvalid
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h300;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h400;
    port_gnt = 1'b1;
    sample();
    chk("rd0_gnt", {29'd0, gnt}, 32'b001);
    step();
    req[0] = 1'b0;
    sample();
    chk("rd0_wait_gnt2", {31'd0, gnt[2]}, 32'd0);
    chk("rd0_wait_req", {31'd0, port_req}, 32'd0);
    step();
    port_rvalid = 1'b1; port_rdata = 32'hCAFE_F00D;
    sample();
    chk("rd0_rvalid", {29'd0, rvalid}, 32'b001);
    chk("rd0_rvalid_gnt2", {31'd0, gnt[2]}, 32'd0);
    step();
    port_rvalid = 1'b0;
    sample();
    chk("rd0_then_gnt2", {29'd0, gnt}, 32'b100);
    $display("[TB] ctrl2 granted after ctrl0 read: gnt=%b", gnt);
    step();
    req[2] = 1'b0; port_gnt = 1'b0;
    step();

    // ctrl2 read times out on the 4th wait cycle
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h500; port_gnt = 1'b1; port_rdata = 32'h0;
    sample();
    chk("to_gnt2", {29'd0, gnt}, 32'b100);
    step();
    req[2] = 1'b0; port_gnt = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      sample();
      chk("to_pending_rvalid", {29'd0, rvalid}, 32'd0);
      chk("to_pending_flag", {31'd0, timeout}, 32'd0);
      step();
    end
    sample();
    chk("to_rvalid2", {29'd0, rvalid}, 32'b100);
    chk("to_rdata2", rdata[2], 32'hDEAD_BEEF);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    $display("[TB] ctrl2 timeout: rvalid=%b rdata=%h timeout=%b", rvalid, rdata[2], timeout);
    step();
    port_rvalid = 1'b1; port_rdata = 32'h1111_1111;
    sample();
    chk("stray_rvalid", {29'd0, rvalid}, 32'd0);
    step();
    port_rvalid = 1'b0;
    step();

    // Async reset mid-read, then priority after release
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h600; port_gnt = 1'b1;
    sample();
    chk("rst_rd1_gnt", {29'd0, gnt}, 32'b010);
    step();
    req[1] = 1'b0; port_gnt = 1'b0; port_rvalid = 1'b1; port_rdata = 32'h5555_AAAA;
    #1;
    chk("pre_rst_rvalid1", {29'd0, rvalid}, 32'b010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("async_rst_req", {31'd0, port_req}, 32'd0);
    chk("async_rst_timeout", {31'd0, timeout}, 32'd0);
    port_rvalid = 1'b0;
    req = 3'b111; we = 3'b111; port_gnt = 1'b1;
    #1;
    chk("async_rst_gnt", {29'd0, gnt}, 32'd0);
    chk("async_rst_req2", {31'd0, port_req}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    sample();
    chk("post_rst_first", {29'd0, gnt}, 32'b001);
    step();
    sample();
`ifdef OBI_MUX_FIXED_PRIO_EN
    chk("post_rst_second", {29'd0, gnt}, 32'b001);
`else
    chk("post_rst_second", {29'd0, gnt}, 32'b010);
`endif
    $display("[TB] after reset: second grant=%b", gnt);
    step();
    req = 3'b000; port_gnt = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_mux_3_to_1.md
Name: obi_mux_3_to_1

Overview:
- N-to-1 counterpart of the team's OBI demux: arbitrates three OBI controllers onto one OBI peripheral port.
- Round-robin arbitration with address-phase locking.
- Single outstanding read, with read responses routed back to the owning controller.
- Optional response timeout returns 32'hDEAD_BEEF.
- Sits at the slave side of the crossbar, in front of shared peripherals and memories.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for rvalid after a read is accepted; 0 disables the timeout.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- ctrlN_req_i  input  1  controller N request (N = 0,1,2; same for every ctrlN line below).
- ctrlN_gnt_o  output  1  controller N grant.
- ctrlN_addr_i  input  32  address.
- ctrlN_we_i  input  1  write enable.
- ctrlN_be_i  input  4  byte enables.
- ctrlN_wdata_i  input  32  write data.
- ctrlN_rvalid_o  output  1  read response valid.
- ctrlN_rdata_o  output  32  read data.
- port_req_o  output  1  peripheral request.
- port_gnt_i  input  1  peripheral grant.
- port_addr_o  output  32  address of selected controller.
- port_we_o  output  1  write enable of selected controller.
- port_be_o  output  4  byte enables of selected controller.
- port_wdata_o  output  32  write data of selected controller.
- port_rvalid_i  input  1  peripheral read valid.
- port_rdata_i  input  32  peripheral read data.
- timeout_o  output  1  one-cycle pulse when a read times out.

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE, rr_last=2 (controller 0 highest priority first), lock=0, counter=0.
  - All gnt/rvalid/req outputs 0 and timeout_o=0, immediately and throughout reset.
  - Any in-flight transaction is abandoned.
- States:
  - IDLE: no read outstanding.
  - WAIT_RESP: one read outstanding; owner register holds its index.
- IDLE arbitration:
  - Winner is the first requesting controller scanning from rr_last+1 mod 3 upward.
  - port_* follows the winner; port_req_o = winner's req.
  - ctrlW_gnt_o = port_gnt_i for the winner; all other gnt = 0.
- Address-phase lock:
  - If port_req_o=1 and port_gnt_i=0, the selection is registered (lock=1) and held until the grant.
  - Addr/we/be/wdata stay stable to the peripheral while locked.
  - lock clears on the grant.
- Accept (port_req_o && port_gnt_i):
  - rr_last <= winner, for both reads and writes.
  - Read (we=0): owner <= winner, go to WAIT_RESP, counter <= 0.
  - Write: remain in IDLE; no rvalid is generated for writes (matches demux).
- WAIT_RESP:
  - port_req_o=0; all ctrl gnt=0.
  - ctrl[owner]_rvalid_o = port_rvalid_i.
  - On port_rvalid_i, return to IDLE next cycle. No new grant in the rvalid cycle, so zero-wait back-to-back reads cost 1 extra cycle.
- rdata: ctrlN_rdata_o = port_rdata_i for all N, except the timeout override below.
- Timeout (TIMEOUT_CYCLES>0):
  - counter increments each WAIT_RESP cycle without rvalid.
  - In the cycle counter == TIMEOUT_CYCLES-1 with no rvalid:
    - ctrl[owner]_rvalid_o=1 and ctrl[owner]_rdata_o=32'hDEAD_BEEF;
    - timeout_o=1;
    - go to IDLE.
  - rvalid in that same cycle wins; no timeout.
- Stray rvalid in IDLE: ignored, not routed.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Optional Feature:
- OBI_MUX_FIXED_PRIO_EN defined: fixed priority 0>1>2; rr_last is unused and not updated; lock behaviour is unchanged.
- Undefined: round-robin as above.

Decomposition:
- obi_pkg holds:
  - OBI_DEADBEEF = 32'hDEAD_BEEF;
  - state encodings IDLE/WAIT_RESP;
  - 2-bit controller index width/constants.
- One sub-module, obi_rr_arbiter_3: 3 requests plus advance strobe in; one-hot grant and index out; owns rr_last, lock and the fixed-priority macro.
- The mux, response tracking and timeout stay in the top module.

Test Plan:
- All three controllers issue writes simultaneously, port_gnt_i=1 every cycle -> grants go to 0,1,2,0 on consecutive cycles; no rvalid appears.
- ctrl1 reads 0x100; peripheral gnt after 3 cycles, rvalid+0x12345678 2 cycles later -> ctrl1 sees gnt in cycle 3 and rvalid with 0x12345678; port_addr_o stays 0x100 while gnt is low even if ctrl2 raises req.
- Read accepted from ctrl0 while ctrl2 requests -> ctrl2 gnt held 0 until the cycle after rvalid, then granted.
- TIMEOUT_CYCLES=4, read from ctrl2, no rvalid -> 4th WAIT_RESP cycle gives ctrl2_rvalid_o=1, rdata 0xDEADBEEF, timeout_o=1; a later rvalid in IDLE is not routed.
- rst_ni asserted asynchronously mid-WAIT_RESP -> all outputs 0 immediately; after release ctrl0 wins simultaneous requests; repeat with OBI_MUX_FIXED_PRIO_EN -> ctrl0 wins every time.
